// File: rtl/wisc_mem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access controller.
// Optional feature macro: MEM_WBUF_EN (adds the DRAIN state for the posted write buffer).
package wisc_mem_pkg;

  localparam int unsigned DW_DEF          = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  // Sticky error vector layout
  localparam int unsigned ERR_W        = 2;
  localparam int unsigned ERR_CONFLICT = 0;
  localparam int unsigned ERR_TIMEOUT  = 1;

`ifdef MEM_WBUF_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT_RD = 3'd2,
    DONE    = 3'd3,
    DRAIN   = 3'd4
  } mac_state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } mac_state_t;
`endif

endpackage

// File: rtl/mem_write_buffer.sv
// One-entry posted write buffer for the MEM stage (used only with MEM_WBUF_EN).
// Ports: clk, rst_n; load_i captures addr_i/data_i; clr_i invalidates (load wins);
//        lookup_addr_i compared against the held entry -> hit_c_o (combinational);
//        valid_o/addr_o/data_o are the registered entry.
module mem_write_buffer #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clr_i,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] lookup_addr_i,
  output logic          valid_o,
  output logic [DW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          hit_c_o
);

  logic          valid_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] data_q;

  // Entry registers; a reload in the same cycle as a drain keeps the entry valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign hit_c_o = valid_q && (addr_q == lookup_addr_i);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage responder: runs the data-memory request/grant/rvalid handshake for
// loads and stores from EX/MEM and freezes the pipeline (pipe_adv=0) meanwhile.
// Optional feature macro: MEM_WBUF_EN (zero-stall posted stores via mem_write_buffer).
// Ports: clk, rst_n; memread/memwrite/addr/wdata from EX/MEM; pipe_adv (combinational);
//        rdata (last load data); mem_req/mem_we/mem_addr/mem_wdata/mem_gnt/mem_rvalid/
//        mem_rdata memory port; err sticky {timeout, rd_wr_conflict}.
module mem_access_ctrl
  import wisc_mem_pkg::*;
#(
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [DW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  output logic             pipe_adv,
  output logic [DW-1:0]    rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [DW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [DW-1:0]    mem_rdata,
  output logic [ERR_W-1:0] err
);

  localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  mac_state_t       state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [DW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             pipe_adv_c;
  logic             wd_expired_c;

  assign wd_expired_c = (wd_q == WD_W'(TIMEOUT_CYC - 1));

`ifdef MEM_WBUF_EN
  logic          wb_load_c;
  logic          wb_clr_c;
  logic          wb_valid;
  logic [DW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_hit_c;

  mem_write_buffer #(.DW(DW)) u_wbuf (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (wb_load_c),
    .clr_i         (wb_clr_c),
    .addr_i        (addr),
    .data_i        (wdata),
    .lookup_addr_i (addr),
    .valid_o       (wb_valid),
    .addr_o        (wb_addr),
    .data_o        (wb_data),
    .hit_c_o       (wb_hit_c)
  );
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
    end
  end

  // Next-state, handshake and watchdog
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    wd_d        = wd_q;
    pipe_adv_c  = 1'b0;
`ifdef MEM_WBUF_EN
    wb_load_c   = 1'b0;
    wb_clr_c    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (memread && memwrite) err_d[ERR_CONFLICT] = 1'b1;
`ifdef MEM_WBUF_EN
        if (memwrite) begin
          // Empty buffer absorbs the store without stalling; otherwise drain first
          if (!wb_valid) begin
            wb_load_c  = 1'b1;
            pipe_adv_c = 1'b1;
          end
        end else if (memread && wb_hit_c) begin
          rdata_d = wb_data;
          state_d = DONE;
        end else if (memread && !wb_valid) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          wd_d        = '0;
        end else if (!memread) begin
          pipe_adv_c = 1'b1;
        end
        // Drain whenever no load is about to be served from memory or the buffer
        if (wb_valid && !(memread && !memwrite && wb_hit_c)) begin
          state_d     = DRAIN;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_addr;
          mem_wdata_d = wb_data;
        end
`else
        if (memread || memwrite) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = memwrite;
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          wd_d        = '0;
        end else begin
          pipe_adv_c = 1'b1;
        end
`endif
      end

      REQ, WAIT_RD: begin
        wd_d = wd_q + WD_W'(1);
        if (wd_expired_c) begin
          // Abort: report, release the port, return zero for an abandoned load
          err_d[ERR_TIMEOUT] = 1'b1;
          mem_req_d          = 1'b0;
          if (!mem_we_q) rdata_d = '0;
          state_d            = DONE;
        end else if (state_q == REQ) begin
          if (mem_gnt) begin
            mem_req_d = 1'b0;
            state_d   = mem_we_q ? DONE : WAIT_RD;
          end
        end else if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end
      end

      DONE: begin
        pipe_adv_c = 1'b1;
        state_d    = IDLE;
      end

`ifdef MEM_WBUF_EN
      DRAIN: begin
        pipe_adv_c = !(memread || memwrite);
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          wb_clr_c  = 1'b1;
          state_d   = IDLE;
          // A store arriving as the entry leaves refills the buffer immediately
          if (memwrite) begin
            wb_load_c  = 1'b1;
            pipe_adv_c = 1'b1;
            if (memread) err_d[ERR_CONFLICT] = 1'b1;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  assign pipe_adv  = pipe_adv_c && rst_n;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load, delayed-grant store, read/write conflict,
// watchdog abort, asynchronous reset mid-access and (with MEM_WBUF_EN) write buffering.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread, memwrite;
  logic [15:0] addr, wdata;
  logic        pipe_adv;
  logic [15:0] rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [15:0] mem_rdata;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;
  int lows;

  mem_access_ctrl #(.DW(16), .TIMEOUT_CYC(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memread    (memread),
    .memwrite   (memwrite),
    .addr       (addr),
    .wdata      (wdata),
    .pipe_adv   (pipe_adv),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs just after the rising edge, let logic settle, return
  task automatic cyc(input logic mr, input logic mw, input logic [15:0] a, input logic [15:0] wd,
                     input logic g, input logic rv, input logic [15:0] rd);
    @(posedge clk);
    #1;
    memread    = mr;
    memwrite   = mw;
    addr       = a;
    wdata      = wd;
    mem_gnt    = g;
    mem_rvalid = rv;
    mem_rdata  = rd;
    #1;
  endtask

  // Load with immediate grant and rvalid one cycle later; counts frozen cycles
  task automatic load_txn(input logic [15:0] a, input logic [15:0] d, output int n_low);
    n_low = 0;
    cyc(1, 0, a, 16'h0, 0, 0, 16'h0); n_low += int'(!pipe_adv);
    cyc(1, 0, a, 16'h0, 1, 0, 16'h0); n_low += int'(!pipe_adv);
    cyc(1, 0, a, 16'h0, 0, 1, d);     n_low += int'(!pipe_adv);
    cyc(1, 0, a, 16'h0, 0, 0, 16'h0); n_low += int'(!pipe_adv);
  endtask

  initial begin
    rst_n = 1'b0;
    memread = 0; memwrite = 0; addr = 0; wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #12;
    check_eq("rst_pipe_adv", 32'(pipe_adv), 32'h0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    check_eq("rst_mem_req", 32'(mem_req), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;

    cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    check_eq("idle_adv", 32'(pipe_adv), 32'h1);

    // Load 0x0040: gnt on cycle 2, rvalid on cycle 4
    lows = 0;
    cyc(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0);    lows += int'(!pipe_adv);
    cyc(1, 0, 16'h0040, 16'h0, 1, 0, 16'h0);    lows += int'(!pipe_adv);
    check_eq("ld_req", 32'(mem_req), 32'h1);
    check_eq("ld_addr", 32'(mem_addr), 32'h0040);
    check_eq("ld_we", 32'(mem_we), 32'h0);
    cyc(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0);    lows += int'(!pipe_adv);
    check_eq("ld_req_drop", 32'(mem_req), 32'h0);
    cyc(1, 0, 16'h0040, 16'h0, 0, 1, 16'hBEEF); lows += int'(!pipe_adv);
    cyc(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0);
    check_eq("ld_low_cycles", 32'(lows), 32'd4);
    check_eq("ld_done_adv", 32'(pipe_adv), 32'h1);
    check_eq("ld_rdata", 32'(rdata), 32'hBEEF);
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    check_eq("ld_back_idle", 32'(pipe_adv), 32'h1);

    // Store 0x0010 <- 0x1234 with grant withheld for 3 cycles
    cyc(0, 1, 16'h0010, 16'h1234, 0, 0, 16'h0);
    check_eq("st_idle_adv", 32'(pipe_adv), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 16'h0010, 16'h1234, 0, 0, 16'h0);
      check_eq("st_hold_req", 32'(mem_req), 32'h1);
      check_eq("st_hold_bus", {mem_we, mem_addr[14:0], mem_wdata}, {1'b1, 15'h0010, 16'h1234});
      check_eq("st_hold_adv", 32'(pipe_adv), 32'h0);
    end
    cyc(0, 1, 16'h0010, 16'h1234, 1, 0, 16'h0);
    check_eq("st_gnt_req", 32'(mem_req), 32'h1);
    cyc(0, 1, 16'h0010, 16'h1234, 0, 0, 16'h0);
    check_eq("st_done_adv", 32'(pipe_adv), 32'h1);
    check_eq("st_done_req", 32'(mem_req), 32'h0);
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    check_eq("st_single_done", 32'(pipe_adv), 32'h1);
    check_eq("st_err", 32'(err), 32'h0);

    // memread and memwrite together: issued as a write, conflict flagged
    cyc(1, 1, 16'h0030, 16'h5555, 0, 0, 16'h0);
    cyc(1, 1, 16'h0030, 16'h5555, 1, 0, 16'h0);
    check_eq("cf_we", 32'(mem_we), 32'h1);
    check_eq("cf_req", 32'(mem_req), 32'h1);
    cyc(1, 1, 16'h0030, 16'h5555, 0, 0, 16'h0);
    check_eq("cf_done_adv", 32'(pipe_adv), 32'h1);
    check_eq("cf_err", 32'(err), 32'h1);
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

    // Load with no grant: watchdog aborts after 64 cycles in REQ
    cyc(1, 0, 16'h0050, 16'h0, 0, 0, 16'h0);
    check_eq("to_idle_adv", 32'(pipe_adv), 32'h0);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1, 0, 16'h0050, 16'h0, 0, 0, 16'h0);
      if (pipe_adv) break;
      lows++;
    end
    check_eq("to_req_cycles", 32'(lows), 32'd64);
    check_eq("to_adv", 32'(pipe_adv), 32'h1);
    check_eq("to_err", 32'(err), 32'h3);
    check_eq("to_rdata", 32'(rdata), 32'h0);
    check_eq("to_req_off", 32'(mem_req), 32'h0);
    cyc(0, 0, 16'h0, 16'h0, 0, 1, 16'hDEAD);
    check_eq("to_fsm_idle", 32'(pipe_adv), 32'h1);
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    check_eq("to_late_rvalid", 32'(rdata), 32'h0);

    // Load to get nonzero rdata, then reset asynchronously in WAIT_RD of the next load
    load_txn(16'h0060, 16'h1357, lows);
    check_eq("pre_rst_rdata", 32'(rdata), 32'h1357);
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    cyc(1, 0, 16'h0062, 16'h0, 0, 0, 16'h0);
    cyc(1, 0, 16'h0062, 16'h0, 1, 0, 16'h0);
    check_eq("pre_rst_req", 32'(mem_req), 32'h1);
    cyc(1, 0, 16'h0062, 16'h0, 0, 0, 16'h0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_mem_req", 32'(mem_req), 32'h0);
    check_eq("arst_rdata", 32'(rdata), 32'h0);
    check_eq("arst_adv", 32'(pipe_adv), 32'h0);
    check_eq("arst_err", 32'(err), 32'h0);
    memread = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    load_txn(16'h0070, 16'h2468, lows);
    check_eq("post_rst_lows", 32'(lows), 32'd3);
    check_eq("post_rst_adv", 32'(pipe_adv), 32'h1);
    check_eq("post_rst_rdata", 32'(rdata), 32'h2468);
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

`ifdef MEM_WBUF_EN
    // Posted store, forwarded load, then a mismatching load forces a drain first
    cyc(0, 1, 16'h0020, 16'hAAAA, 0, 0, 16'h0);
    check_eq("wb_st_adv", 32'(pipe_adv), 32'h1);
    check_eq("wb_st_req", 32'(mem_req), 32'h0);
    cyc(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0);
    check_eq("wb_fwd_stall", 32'(pipe_adv), 32'h0);
    check_eq("wb_fwd_req", 32'(mem_req), 32'h0);
    cyc(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0);
    check_eq("wb_fwd_adv", 32'(pipe_adv), 32'h1);
    check_eq("wb_fwd_rdata", 32'(rdata), 32'hAAAA);
    check_eq("wb_fwd_noreq", 32'(mem_req), 32'h0);
    cyc(1, 0, 16'h0022, 16'h0, 0, 0, 16'h0);
    check_eq("wb_mis_stall", 32'(pipe_adv), 32'h0);
    cyc(1, 0, 16'h0022, 16'h0, 1, 0, 16'h0);
    check_eq("wb_drain_bus", {mem_req, mem_we, mem_addr[13:0], mem_wdata},
             {1'b1, 1'b1, 14'h0020, 16'hAAAA});
    cyc(1, 0, 16'h0022, 16'h0, 0, 0, 16'h0);
    check_eq("wb_post_drain_req", 32'(mem_req), 32'h0);
    cyc(1, 0, 16'h0022, 16'h0, 1, 0, 16'h0);
    check_eq("wb_rd_bus", {mem_req, mem_we, mem_addr[13:0]}, {1'b1, 1'b0, 14'h0022});
    cyc(1, 0, 16'h0022, 16'h0, 0, 1, 16'h3333);
    cyc(1, 0, 16'h0022, 16'h0, 0, 0, 16'h0);
    check_eq("wb_rd_adv", 32'(pipe_adv), 32'h1);
    check_eq("wb_rd_rdata", 32'(rdata), 32'h3333);
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
